// File: rtl/alu_exec_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec_ctrl_if
// Brief    : Request/response, flush and external-ALU bus of alu_exec_ctrl.
// Revision : 1.0  initial release
// ============================================================================
interface alu_exec_ctrl_if;
  logic        flush;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [31:0] req_a_hi;
  logic [31:0] req_b_hi;
  logic        req_setf;
  logic        req_wide;
  logic [3:0]  alu_opcode;
  logic [31:0] alu_op1;
  logic [31:0] alu_op2;
  logic [3:0]  alu_flag_in;
  logic [31:0] alu_result;
  logic [3:0]  alu_flag_q;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_lo;
  logic [31:0] rsp_hi;
  logic [3:0]  rsp_flags;
  logic        rsp_err;
  logic [3:0]  flags_q;

  // Master: requester plus the external ALU; slave: the controller.
  modport master (
    output flush, req_valid, req_op, req_a, req_b, req_a_hi, req_b_hi,
           req_setf, req_wide, alu_result, alu_flag_q, rsp_ready,
    input  req_ready, alu_opcode, alu_op1, alu_op2, alu_flag_in,
           rsp_valid, rsp_lo, rsp_hi, rsp_flags, rsp_err, flags_q
  );

  modport slave (
    input  flush, req_valid, req_op, req_a, req_b, req_a_hi, req_b_hi,
           req_setf, req_wide, alu_result, alu_flag_q, rsp_ready,
    output req_ready, alu_opcode, alu_op1, alu_op2, alu_flag_in,
           rsp_valid, rsp_lo, rsp_hi, rsp_flags, rsp_err, flags_q
  );
endinterface
`default_nettype wire

// File: rtl/alu_exec_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec_ctrl
// Brief    : Sequences one or two passes through an external ALU, owns NZCV.
// Revision : 1.0  initial release
// ============================================================================
module alu_exec_ctrl #(
  parameter logic [3:0] FLAG_RST = 4'b0000
) (
  input  logic           clk,
  input  logic           rst,
  alu_exec_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXEC  = 2'd1,
    EXEC2 = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_ADC = 4'h1;
  localparam logic [3:0] OP_CLR = 4'hB;
  localparam logic [3:0] OP_MVN = 4'hC;

  state_t      state_q;
  logic [3:0]  op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] a_hi_q;
  logic [31:0] b_hi_q;
  logic        setf_q;
  logic        wide_q;
  logic [31:0] rsp_lo_q;
  logic [31:0] rsp_hi_q;
  logic [3:0]  rsp_flags_q;
  logic        rsp_valid_q;
  logic        rsp_err_q;
  logic [3:0]  flags_q;

  logic        accept;
  logic        op_legal;
  logic [3:0]  wide_flags_d;

  assign bus.req_ready = (state_q == IDLE) && !bus.flush;
  assign accept        = bus.req_valid && bus.req_ready;
  assign op_legal      = (bus.req_op <= OP_MVN);

  // Wide Z must span both words; N, C, V come from the high pass alone.
  assign wide_flags_d  = {bus.alu_flag_q[3],
                          rsp_flags_q[2] & bus.alu_flag_q[2],
                          bus.alu_flag_q[1:0]};

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_lo    = rsp_lo_q;
  assign bus.rsp_hi    = rsp_hi_q;
  assign bus.rsp_flags = rsp_flags_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.flags_q   = flags_q;

  always_comb begin
    bus.alu_opcode  = OP_CLR;
    bus.alu_op1     = 32'h0;
    bus.alu_op2     = 32'h0;
    bus.alu_flag_in = flags_q;
    case (state_q)
      EXEC: begin
        bus.alu_opcode = op_q;
        bus.alu_op1    = a_q;
        bus.alu_op2    = b_q;
      end
      EXEC2: begin
        // Pass-1 carry still sits in the temporary flags at this point.
        bus.alu_opcode  = OP_ADC;
        bus.alu_op1     = a_hi_q;
        bus.alu_op2     = b_hi_q;
        bus.alu_flag_in = {flags_q[3:2], rsp_flags_q[1], flags_q[0]};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      op_q        <= 4'h0;
      a_q         <= 32'h0;
      b_q         <= 32'h0;
      a_hi_q      <= 32'h0;
      b_hi_q      <= 32'h0;
      setf_q      <= 1'b0;
      wide_q      <= 1'b0;
      rsp_lo_q    <= 32'h0;
      rsp_hi_q    <= 32'h0;
      rsp_flags_q <= 4'h0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      flags_q     <= FLAG_RST;
    end else if (bus.flush) begin
      state_q     <= IDLE;
      rsp_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            op_q   <= bus.req_op;
            a_q    <= bus.req_a;
            b_q    <= bus.req_b;
            a_hi_q <= bus.req_a_hi;
            b_hi_q <= bus.req_b_hi;
            setf_q <= bus.req_setf;
            wide_q <= bus.req_wide && (bus.req_op == OP_ADD);
            if (op_legal) begin
              state_q   <= EXEC;
              rsp_err_q <= 1'b0;
            end else begin
              state_q     <= RESP;
              rsp_err_q   <= 1'b1;
              rsp_lo_q    <= 32'h0;
              rsp_hi_q    <= 32'h0;
              rsp_flags_q <= flags_q;
              rsp_valid_q <= 1'b1;
            end
          end
        end
        EXEC: begin
          rsp_lo_q    <= bus.alu_result;
          rsp_flags_q <= bus.alu_flag_q;
          if (wide_q) begin
            state_q <= EXEC2;
          end else begin
            rsp_hi_q    <= 32'h0;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end
        end
        EXEC2: begin
          rsp_hi_q    <= bus.alu_result;
          rsp_flags_q <= wide_flags_d;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
            if (setf_q && !rsp_err_q) begin
              flags_q <= rsp_flags_q;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_exec_ctrl
// Brief    : Directed bench for alu_exec_ctrl with a behavioural NZCV ALU.
// Revision : 1.0  initial release
// ============================================================================
module tb_alu_exec_ctrl;

  localparam logic [3:0] FLAGS_AT_RST = 4'b1001;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  alu_exec_ctrl_if bus ();

  alu_exec_ctrl #(.FLAG_RST(FLAGS_AT_RST)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Returns {carry, overflow, sum} for x + y + cin.
  function automatic logic [33:0] addc(input logic [31:0] x, input logic [31:0] y,
                                       input logic cin);
    logic [32:0] s;
    s = {1'b0, x} + {1'b0, y} + {32'h0, cin};
    return {s[32], (x[31] == y[31]) && (s[31] != x[31]), s[31:0]};
  endfunction

  logic [33:0] m_add;
  logic [31:0] m_res;
  logic        m_c;
  logic        m_v;
  logic        m_arith;
  always_comb begin
    m_add   = 34'h0;
    m_res   = 32'h0;
    m_arith = 1'b1;
    case (bus.alu_opcode)
      4'h0: m_add = addc(bus.alu_op1, bus.alu_op2, 1'b0);
      4'h1: m_add = addc(bus.alu_op1, bus.alu_op2, bus.alu_flag_in[1]);
      4'h2: m_add = addc(bus.alu_op1, ~bus.alu_op2, 1'b1);
      4'h3: m_add = addc(bus.alu_op2, ~bus.alu_op1, 1'b1);
      4'h4: m_add = addc(bus.alu_op1, ~bus.alu_op2, bus.alu_flag_in[1]);
      4'h9: m_add = addc(bus.alu_op1, 32'h0, 1'b1);
      4'hA: m_add = addc(bus.alu_op1, 32'hFFFF_FFFF, 1'b0);
      default: m_arith = 1'b0;
    endcase
    case (bus.alu_opcode)
      4'h5:    m_res = bus.alu_op1 & bus.alu_op2;
      4'h6:    m_res = bus.alu_op1 | bus.alu_op2;
      4'h7:    m_res = bus.alu_op1 ^ bus.alu_op2;
      4'h8:    m_res = bus.alu_op2;
      4'hC:    m_res = ~bus.alu_op2;
      4'hB:    m_res = 32'h0;
      default: m_res = m_add[31:0];
    endcase
    m_c = m_arith ? m_add[33] : bus.alu_flag_in[1];
    m_v = m_arith ? m_add[32] : bus.alu_flag_in[0];
    bus.alu_result = m_res;
    bus.alu_flag_q = {m_res[31], m_res == 32'h0, m_c, m_v};
  end

  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] ahi, input logic [31:0] bhi,
                      input logic setf, input logic wide);
    @(negedge clk);
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_a_hi  = ahi;
    bus.req_b_hi  = bhi;
    bus.req_setf  = setf;
    bus.req_wide  = wide;
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready got=%b exp=1", bus.req_ready); end
    n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got=%b exp=0", bus.rsp_valid); end
    n_cmp++; if (bus.flags_q !== FLAGS_AT_RST) begin n_err++; $display("FAIL rst_flags_q got=%b exp=%b", bus.flags_q, FLAGS_AT_RST); end
    n_cmp++; if (bus.rsp_lo !== 32'h0 || bus.rsp_hi !== 32'h0) begin n_err++; $display("FAIL rst_payload got=%h/%h exp=0/0", bus.rsp_hi, bus.rsp_lo); end
    n_cmp++; if (bus.rsp_flags !== 4'h0 || bus.rsp_err !== 1'b0) begin n_err++; $display("FAIL rst_flags_err got=%b/%b exp=0000/0", bus.rsp_flags, bus.rsp_err); end
    n_cmp++; if (bus.alu_opcode !== 4'hB || bus.alu_op1 !== 32'h0) begin n_err++; $display("FAIL rst_alu got=%h/%h exp=b/0", bus.alu_opcode, bus.alu_op1); end
  endtask

  task automatic test_add();
    bus.rsp_ready = 1'b1;
    send(4'h0, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    n_cmp++; if (bus.alu_opcode !== 4'h0 || bus.alu_op1 !== 32'hFFFF_FFFF || bus.alu_op2 !== 32'h1) begin n_err++; $display("FAIL add_alu_drive got=%h/%h/%h exp=0/ffffffff/1", bus.alu_opcode, bus.alu_op1, bus.alu_op2); end
    n_cmp++; if (bus.alu_flag_in !== FLAGS_AT_RST) begin n_err++; $display("FAIL add_flag_in got=%b exp=%b", bus.alu_flag_in, FLAGS_AT_RST); end
    n_cmp++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b0) begin n_err++; $display("FAIL add_early got=%b/%b exp=0/0", bus.rsp_valid, bus.req_ready); end
    @(negedge clk);
    n_cmp++; if (bus.rsp_valid !== 1'b1) begin n_err++; $display("FAIL add_latency got=%b exp=1", bus.rsp_valid); end
    n_cmp++; if (bus.rsp_lo !== 32'h0 || bus.rsp_hi !== 32'h0) begin n_err++; $display("FAIL add_result got=%h/%h exp=0/0", bus.rsp_hi, bus.rsp_lo); end
    n_cmp++; if (bus.rsp_flags !== 4'b0110 || bus.rsp_err !== 1'b0) begin n_err++; $display("FAIL add_rsp_flags got=%b/%b exp=0110/0", bus.rsp_flags, bus.rsp_err); end
    @(negedge clk);
    n_cmp++; if (bus.flags_q !== 4'b0110) begin n_err++; $display("FAIL add_commit got=%b exp=0110", bus.flags_q); end
    n_cmp++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin n_err++; $display("FAIL add_done got=%b/%b exp=0/1", bus.rsp_valid, bus.req_ready); end
  endtask

  task automatic test_wide();
    send(4'h0, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h0, 1'b0, 1'b1);
    @(negedge clk);
    n_cmp++; if (bus.alu_opcode !== 4'h0 || bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL wide_pass1 got=%h/%b exp=0/0", bus.alu_opcode, bus.rsp_valid); end
    @(negedge clk);
    n_cmp++; if (bus.alu_opcode !== 4'h1 || bus.alu_op1 !== 32'h0 || bus.alu_op2 !== 32'h0) begin n_err++; $display("FAIL wide_pass2_drive got=%h/%h/%h exp=1/0/0", bus.alu_opcode, bus.alu_op1, bus.alu_op2); end
    n_cmp++; if (bus.alu_flag_in !== 4'b0110 || bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL wide_pass2_fin got=%b/%b exp=0110/0", bus.alu_flag_in, bus.rsp_valid); end
    @(negedge clk);
    n_cmp++; if (bus.rsp_valid !== 1'b1 || bus.rsp_lo !== 32'h0 || bus.rsp_hi !== 32'h1) begin n_err++; $display("FAIL wide_result got=%b/%h/%h exp=1/1/0", bus.rsp_valid, bus.rsp_hi, bus.rsp_lo); end
    n_cmp++; if (bus.rsp_flags !== 4'b0000) begin n_err++; $display("FAIL wide_flags got=%b exp=0000", bus.rsp_flags); end
    @(negedge clk);
    n_cmp++; if (bus.flags_q !== 4'b0110) begin n_err++; $display("FAIL wide_nosetf got=%b exp=0110", bus.flags_q); end
  endtask

  task automatic test_illegal();
    send(4'hE, 32'h123, 32'h456, 32'h0, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    n_cmp++; if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b1) begin n_err++; $display("FAIL ill_err got=%b/%b exp=1/1", bus.rsp_valid, bus.rsp_err); end
    n_cmp++; if (bus.rsp_lo !== 32'h0 || bus.rsp_hi !== 32'h0) begin n_err++; $display("FAIL ill_payload got=%h/%h exp=0/0", bus.rsp_hi, bus.rsp_lo); end
    n_cmp++; if (bus.rsp_flags !== 4'b0110 || bus.alu_opcode !== 4'hB) begin n_err++; $display("FAIL ill_flags got=%b/%h exp=0110/b", bus.rsp_flags, bus.alu_opcode); end
    @(negedge clk);
    n_cmp++; if (bus.flags_q !== 4'b0110 || bus.req_ready !== 1'b1) begin n_err++; $display("FAIL ill_after got=%b/%b exp=0110/1", bus.flags_q, bus.req_ready); end
    // Following request: all-zero wide add checks the two-word Z merge.
    send(4'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1);
    @(negedge clk);
    n_cmp++; if (bus.rsp_err !== 1'b0 || bus.alu_opcode !== 4'h0) begin n_err++; $display("FAIL ill_next_accept got=%b/%h exp=0/0", bus.rsp_err, bus.alu_opcode); end
    @(negedge clk);
    n_cmp++; if (bus.alu_flag_in !== 4'b0100) begin n_err++; $display("FAIL wz_flag_in got=%b exp=0100", bus.alu_flag_in); end
    @(negedge clk);
    n_cmp++; if (bus.rsp_valid !== 1'b1 || bus.rsp_flags !== 4'b0100) begin n_err++; $display("FAIL wz_flags got=%b/%b exp=1/0100", bus.rsp_valid, bus.rsp_flags); end
    @(negedge clk);
    n_cmp++; if (bus.flags_q !== 4'b0100) begin n_err++; $display("FAIL wz_commit got=%b exp=0100", bus.flags_q); end
  endtask

  task automatic test_wide_ignored();
    send(4'h2, 32'd9, 32'd3, 32'd55, 32'd1, 1'b1, 1'b1);
    repeat (2) @(negedge clk);
    n_cmp++; if (bus.rsp_valid !== 1'b1 || bus.rsp_lo !== 32'd6 || bus.rsp_hi !== 32'h0) begin n_err++; $display("FAIL wign_result got=%b/%h/%h exp=1/0/6", bus.rsp_valid, bus.rsp_hi, bus.rsp_lo); end
    n_cmp++; if (bus.rsp_flags !== 4'b0010) begin n_err++; $display("FAIL wign_flags got=%b exp=0010", bus.rsp_flags); end
    @(negedge clk);
    n_cmp++; if (bus.flags_q !== 4'b0010) begin n_err++; $display("FAIL wign_commit got=%b exp=0010", bus.flags_q); end
  endtask

  task automatic test_backpressure();
    bus.rsp_ready = 1'b0;
    send(4'h2, 32'd5, 32'd5, 32'h0, 32'h0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (bus.rsp_valid !== 1'b1 || bus.rsp_lo !== 32'h0 || bus.rsp_flags !== 4'b0110) begin n_err++; $display("FAIL bp_hold[%0d] got=%b/%h/%b exp=1/0/0110", i, bus.rsp_valid, bus.rsp_lo, bus.rsp_flags); end
      n_cmp++; if (bus.flags_q !== 4'b0010) begin n_err++; $display("FAIL bp_flags_q[%0d] got=%b exp=0010", i, bus.flags_q); end
      if (i < 3) @(negedge clk);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.rsp_valid !== 1'b0 || bus.flags_q !== 4'b0010) begin n_err++; $display("FAIL bp_release got=%b/%b exp=0/0010", bus.rsp_valid, bus.flags_q); end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  ops  [3] = '{4'hC, 4'h7, 4'h9};
    logic [31:0] opa  [3] = '{32'h0, 32'hA5A5_A5A5, 32'h7FFF_FFFF};
    logic [31:0] opb  [3] = '{32'h0, 32'hA5A5_A5A5, 32'h0};
    logic        sf   [3] = '{1'b1, 1'b1, 1'b0};
    logic [31:0] elo  [3] = '{32'hFFFF_FFFF, 32'h0, 32'h8000_0000};
    logic [3:0]  efl  [3] = '{4'b1010, 4'b0110, 4'b1001};
    logic [3:0]  efq  [3] = '{4'b1010, 4'b0110, 4'b0110};
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send(ops[i], opa[i], opb[i], 32'h0, 32'h0, sf[i], 1'b0);
      @(negedge clk);
      n_cmp++; if (bus.req_ready !== 1'b0) begin n_err++; $display("FAIL b2b_busy[%0d] got=%b exp=0", i, bus.req_ready); end
      @(negedge clk);
      n_cmp++; if (bus.rsp_valid !== 1'b1 || bus.rsp_lo !== elo[i] || bus.rsp_flags !== efl[i]) begin n_err++; $display("FAIL b2b_rsp[%0d] got=%b/%h/%b exp=1/%h/%b", i, bus.rsp_valid, bus.rsp_lo, bus.rsp_flags, elo[i], efl[i]); end
      n_cmp++; if (bus.flags_q !== (i == 0 ? 4'b0010 : efq[i-1])) begin n_err++; $display("FAIL b2b_flags_q[%0d] got=%b", i, bus.flags_q); end
    end
    @(negedge clk);
    n_cmp++; if (bus.flags_q !== efq[2] || bus.req_ready !== 1'b1) begin n_err++; $display("FAIL b2b_end got=%b/%b exp=%b/1", bus.flags_q, bus.req_ready, efq[2]); end
  endtask

  task automatic test_flush();
    send(4'h0, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h0, 1'b1, 1'b1);
    repeat (2) @(negedge clk);
    n_cmp++; if (bus.alu_opcode !== 4'h1) begin n_err++; $display("FAIL fl_in_exec2 got=%h exp=1", bus.alu_opcode); end
    bus.flush = 1'b1;
    @(posedge clk);
    #1 bus.flush = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.alu_opcode !== 4'hB) begin n_err++; $display("FAIL fl_abort got=%b/%b/%h exp=1/0/b", bus.req_ready, bus.rsp_valid, bus.alu_opcode); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (bus.rsp_valid !== 1'b0 || bus.flags_q !== 4'b0110) begin n_err++; $display("FAIL fl_quiet[%0d] got=%b/%b exp=0/0110", i, bus.rsp_valid, bus.flags_q); end
      @(negedge clk);
    end
    bus.flush     = 1'b1;
    bus.req_op    = 4'h0;
    bus.req_wide  = 1'b0;
    bus.req_valid = 1'b1;
    #1;
    n_cmp++; if (bus.req_ready !== 1'b0) begin n_err++; $display("FAIL fl_idle_ready got=%b exp=0", bus.req_ready); end
    @(posedge clk);
    #1 begin bus.flush = 1'b0; bus.req_valid = 1'b0; end
    @(negedge clk);
    n_cmp++; if (bus.alu_opcode !== 4'hB || bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL fl_idle_noaccept got=%h/%b exp=b/0", bus.alu_opcode, bus.rsp_valid); end
  endtask

  task automatic test_rst_in_resp();
    bus.rsp_ready = 1'b0;
    send(4'h0, 32'd1, 32'd2, 32'h0, 32'h0, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    n_cmp++; if (bus.rsp_valid !== 1'b1 || bus.rsp_lo !== 32'd3) begin n_err++; $display("FAIL rr_resp got=%b/%h exp=1/3", bus.rsp_valid, bus.rsp_lo); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (bus.flags_q !== FLAGS_AT_RST || bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL rr_async got=%b/%b exp=%b/0", bus.flags_q, bus.rsp_valid, FLAGS_AT_RST); end
    n_cmp++; if (bus.rsp_lo !== 32'h0 || bus.rsp_flags !== 4'h0) begin n_err++; $display("FAIL rr_payload got=%h/%b exp=0/0000", bus.rsp_lo, bus.rsp_flags); end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL rr_ready got=%b exp=1", bus.req_ready); end
    @(negedge clk);
    n_cmp++; if (bus.flags_q !== FLAGS_AT_RST || bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL rr_after got=%b/%b exp=%b/0", bus.flags_q, bus.rsp_valid, FLAGS_AT_RST); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst           = 1'b1;
    bus.flush     = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_op    = 4'h0;
    bus.req_a     = 32'h0;
    bus.req_b     = 32'h0;
    bus.req_a_hi  = 32'h0;
    bus.req_b_hi  = 32'h0;
    bus.req_setf  = 1'b0;
    bus.req_wide  = 1'b0;
    bus.rsp_ready = 1'b0;
    test_reset();
    test_add();
    test_wide();
    test_illegal();
    test_wide_ignored();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_rst_in_resp();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/alu_exec_ctrl.md
ALU_EXEC_CTRL -- requirements
Module: alu_exec_ctrl

Interface
REQ-001 Parameter FLAG_RST, default 4'b0000: reset value of the architectural NZCV flag register.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 flush  input  1  synchronous abort of any in-flight operation.
REQ-005 req_valid  input  1 / req_ready  output  1  request handshake.
REQ-006 req_op  input  4  ALU opcode: 0 ADD, 1 ADC, 2 SUB, 3 RSB, 4 SBC, 5 AND, 6 ORR, 7 EOR, 8 MOV, 9 INC, A DEC, B CLR, C MVN; D-F illegal.
REQ-007 req_a, req_b  input  32  low-word operands; req_a_hi, req_b_hi  input  32  high-word operands for a wide add.
REQ-008 req_setf  input  1  commit flags on completion; req_wide  input  1  64-bit add request.
REQ-009 alu_opcode  output  4 / alu_op1, alu_op2  output  32 / alu_flag_in  output  4  drive to the external combinational ALU.
REQ-010 alu_result  input  32 / alu_flag_q  input  4  combinational return from the ALU, NZCV order [3:0].
REQ-011 rsp_valid  output  1 / rsp_ready  input  1  response handshake.
REQ-012 rsp_lo, rsp_hi  output  32 / rsp_flags  output  4 / rsp_err  output  1  response payload.
REQ-013 flags_q  output  4  architectural NZCV register.

Function
REQ-014 FSM states: IDLE, EXEC, EXEC2, RESP; req_ready SHALL be 1 only in IDLE with flush=0.
REQ-015 IDLE: on req_valid&req_ready, opcode, operands, setf and wide are latched; next state EXEC (legal op) or RESP with rsp_err=1 (op D-F).
REQ-016 req_wide is honoured only with req_op=0; for any other op it is ignored (single pass).
REQ-017 EXEC: alu_opcode=latched op, alu_op1=a, alu_op2=b, alu_flag_in=flags_q; at the edge, rsp_lo<=alu_result, temporary flags<=alu_flag_q; next EXEC2 if wide else RESP.
REQ-018 EXEC2: alu_opcode=1 (ADC), alu_op1=a_hi, alu_op2=b_hi, alu_flag_in={flags_q[3:2], pass-1 C, flags_q[0]}; at the edge rsp_hi<=alu_result.
REQ-019 Wide flags: N,C,V from pass 2; Z = pass-1 Z AND pass-2 Z.
REQ-020 Non-wide ops SHALL set rsp_hi=0.
REQ-021 Outside EXEC/EXEC2, alu_opcode=B (CLR) and alu_op1/op2=0.
REQ-022 RESP: rsp_valid=1; payload held stable until rsp_ready=1; on handshake next state IDLE.
REQ-023 On RESP handshake with setf=1 and rsp_err=0, flags_q<=rsp_flags; otherwise flags_q unchanged.
REQ-024 Latency: accept at edge t -> rsp_valid high after edge t+1 (single) or t+2 (wide); zero-wait back-to-back throughput is one op per 3 cycles (single).
REQ-025 Illegal op: rsp_err=1, rsp_lo=rsp_hi=0, rsp_flags=flags_q, no flag commit.
REQ-026 flush=1 in any state -> next state IDLE, rsp_valid low next cycle, no flag commit; flush with a simultaneous RESP handshake also suppresses the commit.
REQ-027 flush=1 with req_valid=1 in IDLE: request not accepted (req_ready=0).

Reset
REQ-028 rst=1 asynchronously forces state IDLE, flags_q=FLAG_RST, rsp_valid=0, rsp_err=0, rsp_lo=rsp_hi=0, rsp_flags=0, latched operands=0.
REQ-029 Reset mid-operation abandons the operation with no flag commit; req_ready=1 in the first cycle after rst deasserts.

Verification
REQ-030 ADD a=0xFFFFFFFF b=1 setf=1, rsp_ready=1 -> rsp_lo=0, rsp_flags=0110, flags_q=0110 after handshake, rsp_valid 2 cycles after accept.
REQ-031 Wide ADD a=0xFFFFFFFF,a_hi=0, b=1,b_hi=0 -> rsp_lo=0, rsp_hi=1, rsp_flags=0000 (Z=0 since hi nonzero), valid 3 cycles after accept.
REQ-032 SUB a=5 b=5 setf=0, rsp_ready held low 4 cycles -> rsp_lo=0, flags=0110 stable while waiting, flags_q unchanged.
REQ-033 req_op=0xE -> rsp_err=1, rsp_lo=0, flags_q unchanged; next request accepted normally.
REQ-034 flush asserted in EXEC2 of a wide add -> no response, flags_q unchanged, req_ready=1 next cycle.
REQ-035 rst asserted in RESP with setf=1 -> flags_q=FLAG_RST immediately, rsp_valid=0.
